// File: rtl/h14rx_decoding_top.sv
// HDMI 1.4 TMDS receive decoder: classifies a three-channel symbol stream into
// control/preamble/guard/video/data-island periods and recovers the payload bits.
package h14tx_pkg;
    typedef enum logic [2:0] {
        Control,
        VideoPreamble,
        VideoGuard,
        VideoActive,
        DataIslandPreamble,
        DataIslandGuard,
        DataIslandActive
    } period_t;
endpackage

module h14rx_decoding_top
    import h14tx_pkg::*;
#(
    parameter int unsigned MaxPackets  = 18,
    parameter int unsigned PreambleLen = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0][9:0] symbol,
    output period_t         period,
    output logic            hsync,
    output logic            vsync,
    output logic [3:0]      ctl,
    output logic [2:0][7:0] video,
    output logic [2:0][3:0] data,
    output logic            sym_err,
    output logic            seq_err
);
    localparam int unsigned PcntW = $clog2(PreambleLen + 1);
    localparam int unsigned PktW  = $clog2(MaxPackets + 1);
    localparam logic [PcntW-1:0] PreLen = PcntW'(PreambleLen);
    localparam logic [PktW-1:0]  PktMax = PktW'(MaxPackets);
    localparam logic [9:0] GuardA    = 10'b1011001100;
    localparam logic [9:0] GuardB    = 10'b0100110011;
    localparam logic [3:0] CtlVideo  = 4'b0001;
    localparam logic [3:0] CtlIsland = 4'b0101;

    typedef enum logic [2:0] {
        CTRL, V_GUARD, V_ACT, D_GUARD_LEAD, D_ACT, D_GUARD_TRAIL
    } state_t;

    // {valid, c1, c0}
    function automatic logic [2:0] ctrl_dec(input logic [9:0] s);
        logic [2:0] r;
        case (s)
            10'b1101010100: r = 3'b100;
            10'b0010101011: r = 3'b101;
            10'b0101010100: r = 3'b110;
            10'b1010101011: r = 3'b111;
            default:        r = 3'b000;
        endcase
        return r;
    endfunction

    // {valid, nibble}
    function automatic logic [4:0] terc4_dec(input logic [9:0] s);
        logic [4:0] r;
        case (s)
            10'b1010011100: r = 5'h10;
            10'b1001100011: r = 5'h11;
            10'b1011100100: r = 5'h12;
            10'b1011100010: r = 5'h13;
            10'b0101110001: r = 5'h14;
            10'b0100011110: r = 5'h15;
            10'b0110001110: r = 5'h16;
            10'b0100111100: r = 5'h17;
            10'b1011001100: r = 5'h18;
            10'b0100111001: r = 5'h19;
            10'b0110011100: r = 5'h1A;
            10'b1011000110: r = 5'h1B;
            10'b1010001110: r = 5'h1C;
            10'b1001110001: r = 5'h1D;
            10'b0101100011: r = 5'h1E;
            10'b1011000011: r = 5'h1F;
            default:        r = 5'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] tmds_dec(input logic [9:0] s);
        logic [7:0] d;
        logic [7:0] r;
        d    = s[9] ? ~s[7:0] : s[7:0];
        r[0] = d[0];
        for (int unsigned i = 1; i < 8; i++)
            r[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return r;
    endfunction

    state_t           r_state, w_state;
    logic [PcntW-1:0] r_pcnt, w_pcnt, w_pre_cnt;
    logic [4:0]       r_scnt, w_scnt;
    logic [PktW-1:0]  r_pkt, w_pkt;
    period_t          r_period, w_period, w_pre_period;
    logic             r_hsync, w_hsync, r_vsync, w_vsync;
    logic [3:0]       r_ctl, w_ctl, w_code;
    logic [2:0][7:0]  r_video, w_video, w_px;
    logic [2:0][3:0]  r_data, w_data;
    logic             r_sym_err, w_sym_err, r_seq_err, w_seq_err;
    logic [2:0][2:0]  w_cd;
    logic [2:0][4:0]  w_td;
    logic             w_all_ctrl, w_any_ctrl, w_all_terc, w_vguard, w_dguard;

    always_comb begin
        for (int unsigned ch = 0; ch < 3; ch++) begin
            w_cd[ch] = ctrl_dec(symbol[ch]);
            w_td[ch] = terc4_dec(symbol[ch]);
            w_px[ch] = tmds_dec(symbol[ch]);
        end
    end

    assign w_all_ctrl = w_cd[0][2] & w_cd[1][2] & w_cd[2][2];
    assign w_any_ctrl = w_cd[0][2] | w_cd[1][2] | w_cd[2][2];
    assign w_all_terc = w_td[0][4] & w_td[1][4] & w_td[2][4];
    assign w_code     = {w_cd[2][1:0], w_cd[1][1:0]};
    assign w_vguard   = (symbol[0] == GuardA) && (symbol[1] == GuardB) && (symbol[2] == GuardA);
    assign w_dguard   = w_td[0][4] && (w_td[0][3:2] == 2'b11) &&
                        (symbol[1] == GuardB) && (symbol[2] == GuardB);

    // Run length of an unchanged preamble code, saturating at PreambleLen.
    always_comb begin
        w_pre_cnt    = '0;
        w_pre_period = Control;
        if (w_code == CtlVideo || w_code == CtlIsland) begin
            if (r_pcnt != '0 && w_code == r_ctl)
                w_pre_cnt = (r_pcnt >= PreLen) ? r_pcnt : r_pcnt + 1'b1;
            else
                w_pre_cnt = PcntW'(1);
        end
        if (w_pre_cnt >= PreLen && w_pre_cnt != '0)
            w_pre_period = (w_code == CtlVideo) ? VideoPreamble : DataIslandPreamble;
    end

    always_comb begin
        w_state   = r_state;
        w_pcnt    = '0;
        w_scnt    = r_scnt;
        w_pkt     = r_pkt;
        w_period  = Control;
        w_hsync   = r_hsync;
        w_vsync   = r_vsync;
        w_ctl     = r_ctl;
        w_video   = '0;
        w_data    = '0;
        w_sym_err = 1'b0;
        w_seq_err = 1'b0;
        case (r_state)
            CTRL: begin
                if (w_all_ctrl) begin
                    {w_vsync, w_hsync} = w_cd[0][1:0];
                    w_ctl    = w_code;
                    w_pcnt   = w_pre_cnt;
                    w_period = w_pre_period;
                end else if (r_pcnt >= PreLen && r_ctl == CtlVideo && w_vguard) begin
                    w_state  = V_GUARD;
                    w_period = VideoGuard;
                end else if (r_pcnt >= PreLen && r_ctl == CtlIsland && w_dguard) begin
                    w_state  = D_GUARD_LEAD;
                    w_period = DataIslandGuard;
                    {w_vsync, w_hsync} = w_td[0][1:0];
                end else begin
                    w_sym_err = 1'b1;
                end
            end
            V_GUARD: begin
                if (w_vguard) begin
                    w_state  = V_ACT;
                    w_period = VideoGuard;
                end else begin
                    w_state   = CTRL;
                    w_seq_err = 1'b1;
                end
            end
            V_ACT: begin
                if (w_all_ctrl) begin
                    w_state = CTRL;
                    {w_vsync, w_hsync} = w_cd[0][1:0];
                    w_ctl  = w_code;
                    w_pcnt = w_pre_cnt;
                end else begin
                    w_period  = VideoActive;
                    w_video   = w_px;
                    w_sym_err = w_any_ctrl;
                end
            end
            D_GUARD_LEAD: begin
                if (w_dguard) begin
                    w_state  = D_ACT;
                    w_period = DataIslandGuard;
                    w_scnt   = '0;
                    w_pkt    = '0;
                    {w_vsync, w_hsync} = w_td[0][1:0];
                end else begin
                    w_state   = CTRL;
                    w_seq_err = 1'b1;
                end
            end
            D_ACT: begin
                if (w_dguard && r_scnt == '0 && r_pkt != '0) begin
                    w_state  = D_GUARD_TRAIL;
                    w_period = DataIslandGuard;
                    {w_vsync, w_hsync} = w_td[0][1:0];
                end else if (w_dguard || (r_scnt == '0 && r_pkt == PktMax)) begin
                    w_state   = CTRL;
                    w_seq_err = 1'b1;
                end else begin
                    w_period  = DataIslandActive;
                    w_data    = {w_td[2][3:0], w_td[1][3:0], w_td[0][3:0]};
                    w_sym_err = ~w_all_terc;
                    if (w_td[0][4])
                        {w_vsync, w_hsync} = w_td[0][1:0];
                    w_scnt = r_scnt + 5'd1;
                    if (r_scnt == 5'd31)
                        w_pkt = r_pkt + 1'b1;
                end
            end
            D_GUARD_TRAIL: begin
                w_state = CTRL;
                if (w_dguard) begin
                    w_period = DataIslandGuard;
                    {w_vsync, w_hsync} = w_td[0][1:0];
                end else begin
                    w_seq_err = 1'b1;
                end
            end
            default: w_state = CTRL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= CTRL;
            r_pcnt    <= '0;
            r_scnt    <= '0;
            r_pkt     <= '0;
            r_period  <= Control;
            r_hsync   <= 1'b0;
            r_vsync   <= 1'b0;
            r_ctl     <= '0;
            r_video   <= '0;
            r_data    <= '0;
            r_sym_err <= 1'b0;
            r_seq_err <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_pcnt    <= w_pcnt;
            r_scnt    <= w_scnt;
            r_pkt     <= w_pkt;
            r_period  <= w_period;
            r_hsync   <= w_hsync;
            r_vsync   <= w_vsync;
            r_ctl     <= w_ctl;
            r_video   <= w_video;
            r_data    <= w_data;
            r_sym_err <= w_sym_err;
            r_seq_err <= w_seq_err;
        end
    end

    assign period  = r_period;
    assign hsync   = r_hsync;
    assign vsync   = r_vsync;
    assign ctl     = r_ctl;
    assign video   = r_video;
    assign data    = r_data;
    assign sym_err = r_sym_err;
    assign seq_err = r_seq_err;
endmodule

// File: tb/tb_h14rx_decoding_top.sv
// Scoreboard bench for h14rx_decoding_top: symbols are built with an independent
// encoder, expected outputs are queued at drive time and compared one clock later.
module tb_h14rx_decoding_top;
    import h14tx_pkg::*;

    typedef struct packed {
        period_t         period;
        logic            hsync;
        logic            vsync;
        logic [3:0]      ctl;
        logic [2:0][7:0] video;
        logic [2:0][3:0] data;
        logic            sym_err;
        logic            seq_err;
    } out_t;
    typedef logic [2:0][9:0] sym3_t;

    localparam logic [9:0]      G02 = 10'b1011001100;
    localparam logic [9:0]      G1  = 10'b0100110011;
    localparam logic [3:0][7:0] PIX = {8'h81, 8'h5A, 8'hFF, 8'h00};

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    sym3_t           symbol = '0;
    period_t         period;
    logic            hsync, vsync, sym_err, seq_err;
    logic [3:0]      ctl;
    logic [2:0][7:0] video;
    logic [2:0][3:0] data;

    int    checks   = 0;
    int    failures = 0;
    out_t  exp_q[$];
    sym3_t s_q[$];
    out_t  e_q[$];

    h14rx_decoding_top #(.MaxPackets(18), .PreambleLen(8)) dut (
        .clk(clk), .rst(rst), .symbol(symbol), .period(period),
        .hsync(hsync), .vsync(vsync), .ctl(ctl), .video(video),
        .data(data), .sym_err(sym_err), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] ctrl_enc(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] terc4_enc(input logic [3:0] n);
        case (n)
            4'h0: return 10'b1010011100;  4'h1: return 10'b1001100011;
            4'h2: return 10'b1011100100;  4'h3: return 10'b1011100010;
            4'h4: return 10'b0101110001;  4'h5: return 10'b0100011110;
            4'h6: return 10'b0110001110;  4'h7: return 10'b0100111100;
            4'h8: return 10'b1011001100;  4'h9: return 10'b0100111001;
            4'hA: return 10'b0110011100;  4'hB: return 10'b1011000110;
            4'hC: return 10'b1010001110;  4'hD: return 10'b1001110001;
            4'hE: return 10'b0101100011;  default: return 10'b1011000011;
        endcase
    endfunction

    // mode[0]: 0 = XOR chain, 1 = XNOR chain; mode[1]: invert q[7:0]
    function automatic logic [9:0] tmds_enc(input logic [7:0] b, input logic [1:0] mode);
        logic [7:0] q;
        q[0] = b[0];
        for (int i = 1; i < 8; i++)
            q[i] = mode[0] ? ~(q[i-1] ^ b[i]) : (q[i-1] ^ b[i]);
        return mode[1] ? {1'b1, ~mode[0], ~q} : {1'b0, ~mode[0], q};
    endfunction

    function automatic sym3_t ctl3(input logic [1:0] c0, input logic [1:0] c1, input logic [1:0] c2);
        return {ctrl_enc(c2), ctrl_enc(c1), ctrl_enc(c0)};
    endfunction

    function automatic sym3_t dguard(input logic [3:0] n0);
        return {G1, G1, terc4_enc(n0)};
    endfunction

    function automatic out_t mk(input period_t p, input logic hs, input logic vs,
                                input logic [3:0] c, input logic [23:0] v,
                                input logic [11:0] d, input logic se, input logic qe);
        out_t o;
        o.period = p;  o.hsync = hs;  o.vsync = vs;  o.ctl = c;
        o.video = v;   o.data = d;    o.sym_err = se; o.seq_err = qe;
        return o;
    endfunction

    function automatic out_t cur();
        out_t o;
        o.period = period;  o.hsync = hsync;  o.vsync = vsync;  o.ctl = ctl;
        o.video = video;    o.data = data;    o.sym_err = sym_err; o.seq_err = seq_err;
        return o;
    endfunction

    task automatic add(input sym3_t s, input out_t e);
        s_q.push_back(s);
        e_q.push_back(e);
    endtask

    task automatic clear_lists();
        s_q.delete();
        e_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        symbol = ctl3(2'b00, 2'b00, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic add_island_intro();
        for (int i = 0; i < 8; i++)
            add(ctl3(2'b00, 2'b01, 2'b01),
                mk(i < 7 ? Control : DataIslandPreamble, 1'b0, 1'b0, 4'b0101, '0, '0, 1'b0, 1'b0));
        for (int i = 0; i < 2; i++)
            add(dguard(4'hC), mk(DataIslandGuard, 1'b0, 1'b0, 4'b0101, '0, '0, 1'b0, 1'b0));
    endtask

    task automatic add_island_data(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            logic [3:0] n0, n1, n2;
            n0 = 4'(i);
            n1 = 4'(i * 3);
            n2 = ~n0;
            add({terc4_enc(n2), terc4_enc(n1), terc4_enc(n0)},
                mk(DataIslandActive, n0[0], n0[1], 4'b0101, '0, {n2, n1, n0}, 1'b0, 1'b0));
        end
    endtask

    task automatic test_reset();
        out_t got, exp;
        rst = 1'b1;
        symbol = {G02, G1, G02};
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cur() !== mk(Control, 1'b0, 1'b0, 4'b0000, '0, '0, 1'b0, 1'b0)) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=0", cur());
        end
        rst = 1'b0;
        clear_lists();
        add(ctl3(2'b00, 2'b00, 2'b00), mk(Control, 1'b0, 1'b0, 4'b0000, '0, '0, 1'b0, 1'b0));
        add({G02, G1, G02}, mk(Control, 1'b0, 1'b0, 4'b0000, '0, '0, 1'b1, 1'b0));
        for (int i = 0; i < s_q.size(); i++) begin
            symbol = s_q[i];
            exp_q.push_back(e_q[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = cur();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset_seq[%0d] got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_video();
        out_t got, exp;
        do_reset();
        clear_lists();
        for (int i = 0; i < 10; i++)
            add(ctl3(2'b01, 2'b01, 2'b00),
                mk(i < 7 ? Control : VideoPreamble, 1'b1, 1'b0, 4'b0001, '0, '0, 1'b0, 1'b0));
        for (int i = 0; i < 2; i++)
            add({G02, G1, G02}, mk(VideoGuard, 1'b1, 1'b0, 4'b0001, '0, '0, 1'b0, 1'b0));
        for (int p = 0; p < 4; p++)
            add({tmds_enc(PIX[p], 2'(p + 2)), tmds_enc(PIX[p], 2'(p + 1)), tmds_enc(PIX[p], 2'(p))},
                mk(VideoActive, 1'b1, 1'b0, 4'b0001, {PIX[p], PIX[p], PIX[p]}, '0, 1'b0, 1'b0));
        add(ctl3(2'b01, 2'b00, 2'b00), mk(Control, 1'b1, 1'b0, 4'b0000, '0, '0, 1'b0, 1'b0));
        for (int i = 0; i < s_q.size(); i++) begin
            symbol = s_q[i];
            exp_q.push_back(e_q[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = cur();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL video[%0d] got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_short_preamble();
        out_t got, exp;
        do_reset();
        clear_lists();
        for (int i = 0; i < 7; i++)
            add(ctl3(2'b00, 2'b01, 2'b00), mk(Control, 1'b0, 1'b0, 4'b0001, '0, '0, 1'b0, 1'b0));
        for (int i = 0; i < 2; i++)
            add({G02, G1, G02}, mk(Control, 1'b0, 1'b0, 4'b0001, '0, '0, 1'b1, 1'b0));
        for (int p = 0; p < 4; p++)
            add({tmds_enc(PIX[p], 2'(p)), tmds_enc(PIX[p], 2'(p)), tmds_enc(PIX[p], 2'(p))},
                mk(Control, 1'b0, 1'b0, 4'b0001, '0, '0, 1'b1, 1'b0));
        for (int i = 0; i < s_q.size(); i++) begin
            symbol = s_q[i];
            exp_q.push_back(e_q[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = cur();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL short_preamble[%0d] got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_island();
        out_t got, exp;
        do_reset();
        clear_lists();
        add_island_intro();
        add_island_data(64);
        for (int i = 0; i < 2; i++)
            add(dguard(4'hD), mk(DataIslandGuard, 1'b1, 1'b0, 4'b0101, '0, '0, 1'b0, 1'b0));
        add(ctl3(2'b00, 2'b00, 2'b00), mk(Control, 1'b0, 1'b0, 4'b0000, '0, '0, 1'b0, 1'b0));
        for (int i = 0; i < s_q.size(); i++) begin
            symbol = s_q[i];
            exp_q.push_back(e_q[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = cur();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL island[%0d] got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_mid_packet_guard();
        out_t got, exp;
        do_reset();
        clear_lists();
        add_island_intro();
        add_island_data(17);
        add(dguard(4'hC), mk(Control, 1'b0, 1'b0, 4'b0101, '0, '0, 1'b0, 1'b1));
        add(ctl3(2'b00, 2'b00, 2'b00), mk(Control, 1'b0, 1'b0, 4'b0000, '0, '0, 1'b0, 1'b0));
        for (int i = 0; i < s_q.size(); i++) begin
            symbol = s_q[i];
            exp_q.push_back(e_q[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = cur();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL mid_guard[%0d] got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_max_packets();
        out_t got, exp;
        do_reset();
        clear_lists();
        add_island_intro();
        add_island_data(18 * 32);
        add({terc4_enc(4'hF), terc4_enc(4'h0), terc4_enc(4'h0)},
            mk(Control, 1'b1, 1'b1, 4'b0101, '0, '0, 1'b0, 1'b1));
        add(ctl3(2'b00, 2'b00, 2'b00), mk(Control, 1'b0, 1'b0, 4'b0000, '0, '0, 1'b0, 1'b0));
        for (int i = 0; i < s_q.size(); i++) begin
            symbol = s_q[i];
            exp_q.push_back(e_q[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = cur();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL max_packets[%0d] got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        out_t got, exp;
        do_reset();
        clear_lists();
        add_island_intro();
        add_island_data(10);
        for (int i = 0; i < s_q.size(); i++) begin
            symbol = s_q[i];
            exp_q.push_back(e_q[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = cur();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL async_pre[%0d] got=%h exp=%h", i, got, exp);
            end
        end
        symbol = {terc4_enc(4'h5), terc4_enc(4'hE), terc4_enc(4'hA)};
        #2 rst = 1'b1;
        #1;
        checks++;
        if (cur() !== mk(Control, 1'b0, 1'b0, 4'b0000, '0, '0, 1'b0, 1'b0)) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0", cur());
        end
        @(posedge clk); #1 rst = 1'b0;
        clear_lists();
        for (int i = 0; i < 2; i++)
            add(dguard(4'hC), mk(Control, 1'b0, 1'b0, 4'b0000, '0, '0, 1'b1, 1'b0));
        for (int i = 0; i < 7; i++)
            add(ctl3(2'b00, 2'b01, 2'b01), mk(Control, 1'b0, 1'b0, 4'b0101, '0, '0, 1'b0, 1'b0));
        add(dguard(4'hC), mk(Control, 1'b0, 1'b0, 4'b0101, '0, '0, 1'b1, 1'b0));
        add_island_intro();
        add_island_data(1);
        for (int i = 0; i < s_q.size(); i++) begin
            symbol = s_q[i];
            exp_q.push_back(e_q[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = cur();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL async_post[%0d] got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_video();
        test_short_preamble();
        test_island();
        test_mid_packet_guard();
        test_max_packets();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
